cv32e40p_if_id_voter: RTL and testbench
=======================================

# cv32e40p_if_id_voter

Sits between the triplicated IF/ID pipeline registers and the ID stage. It majority-votes the three copies of each IF/ID field into one set of signals for the decoder, and tracks per-lane disagreement. A lane that keeps disagreeing is retired, and the block degrades to duplex compare. An uncorrectable mismatch suppresses the instruction and raises a refetch request to the controller.

## Interface
- `FT_ENABLE`, 1: 0 passes lane 0 straight through; all status outputs are held at 0 and the FSM stays in `VOTE_TMR`.
- `ERR_THRESHOLD`, 4: number of consecutive mismatching cycles (1..15) after which a lane is marked faulty.
- `CNT_WIDTH`, 16: width of the saturating error counter.
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `instr_valid_id_i` in [2:0]: per-lane valid.
- `instr_rdata_id_i` in [2:0][31:0]: per-lane decompressed instruction.
- `is_compressed_id_i` in [2:0]: per-lane compressed flag.
- `illegal_c_insn_id_i` in [2:0]: per-lane illegal compressed flag.
- `pc_id_i` in [2:0][31:0]: per-lane PC.
- `is_fetch_failed_i` in [2:0]: per-lane fetch-failed flag.
- `instr_valid_o` out 1: voted valid; forced 0 on an uncorrectable cycle or in `VOTE_FAIL`.
- `instr_rdata_o`, `pc_o` out 32 each: voted fields.
- `is_compressed_o`, `illegal_c_insn_o`, `is_fetch_failed_o` out 1 each: voted fields.
- `err_corrected_o` out 1: registered; a mismatch was masked in the previous cycle.
- `err_uncorrectable_o` out 1: registered; an uncorrectable mismatch occurred in the previous cycle.
- `lane_faulty_o` out [2:0]: retired lanes.
- `err_count_o` out CNT_WIDTH: saturating count of cycles with any mismatch.
- `err_clear_i` in 1: clears the counter, lane flags and streak counters.
- `refetch_req_o` out 1: asks the controller to flush and refetch from `pc_o`.
- `refetch_ack_i` in 1: controller has accepted the refetch.

## Operation
- **Bundle.** Each lane is one 68-bit bundle {valid, rdata, compressed, illegal, pc, fetch_failed}. All bundle bits are compared every cycle, whether or not the lane is valid.
- **Vote and mismatch.** The voted bundle is the bitwise 2-of-3 majority. `mm[i]` = lane i ≠ voted bundle.
- **VOTE_TMR.**
  - Outputs = voted bundle.
  - Uncorrectable when no lane equals the voted bundle.
  - Corrected when any `mm[i]` is set but the cycle is not uncorrectable.
- **VOTE_DUPLEX.**
  - Exactly one lane is faulty.
  - Outputs = lowest-indexed healthy lane.
  - Any difference between the two healthy lanes is uncorrectable.
  - The faulty lane's `mm` is ignored.
- **VOTE_FAIL.**
  - `instr_valid_o` = 0; `refetch_req_o` = 1.
  - On `refetch_ack_i`, go to DUPLEX if any lane is faulty, else TMR.
- **Streak counters.**
  - Per healthy lane: increment on `mm[i]`, clear on a match, saturate at `ERR_THRESHOLD`.
  - Reaching `ERR_THRESHOLD` sets `lane_faulty[i]` and moves TMR to DUPLEX.
- **FSM transitions.**
  - Two lanes reaching the threshold in the same cycle: both flagged, go to FAIL.
  - A threshold event while in DUPLEX: go to FAIL.
  - An uncorrectable cycle in TMR or DUPLEX: go to FAIL.
- **err_count.** +1 per cycle with any mismatch (corrected or uncorrectable), saturating at all-ones.
- **err_clear_i.**
  - Clears the counter, `lane_faulty`, and the streak counters; has priority over increment.
  - Outside FAIL: next state TMR.
  - In FAIL: the state is unchanged, and `refetch_ack_i` then returns to TMR.

## Timing
- **Voted data path.** Combinational, zero latency; the ID stage consumes it in the same cycle.
- **Same-cycle suppression.** On an uncorrectable cycle, `instr_valid_o` is 0 combinationally, so a corrupted instruction never issues.
- **Registered outputs.** State, flags, counters, `err_*_o` and `refetch_req_o` update on the clock edge. They reflect the previous cycle's evaluation.
- **Refetch handshake.**
  - `refetch_req_o` rises the cycle after detection and stays high until the cycle `refetch_ack_i` is sampled high.
  - It drops in the following cycle.
  - An ack without a request is ignored.
- **Reset values (asserted or mid-operation):**
  - State `VOTE_TMR`.
  - `lane_faulty_o`, streaks, `err_count_o`, `err_*_o`, `refetch_req_o` all 0.
  - Voted outputs follow the inputs, which are 0 under IF reset.

## Structure
- **Shared package:** in `cv32e40p_pkg`:
  - `if_id_bundle_t` (68-bit packed struct).
  - `if_voter_state_e` {`VOTE_TMR`, `VOTE_DUPLEX`, `VOTE_FAIL`}.
  - `IF_ID_BUNDLE_W` = 68.
- **Sub-module:** `cv32e40p_bitwise_voter`, parameter `WIDTH`.
  - Inputs: three words.
  - Outputs: the voted word, `mm[2:0]`, and `no_match`.
- **Top level:** the FSM, streak counters and error counter are in the top module.

## Test plan
- **Clean traffic:** three identical lanes (rdata=0x00A00093, pc=0x80) → outputs equal the lanes; `err_count_o`=0; state TMR.
- **Single-cycle flip:** lane 1 rdata bit 5 flipped for 1 cycle → correct voted output; `err_corrected_o`=1 next cycle; `err_count_o`=1; `lane_faulty_o`=0.
- **Persistent fault:** lane 2 pc differs for 4 consecutive cycles → `lane_faulty_o`=3'b100 after the 4th edge; state DUPLEX; outputs from lane 0.
- **Uncorrectable in DUPLEX:** lanes 0 and 1 differ → `instr_valid_o`=0 in the same cycle; `refetch_req_o`=1 next cycle and held 3 cycles until ack; then DUPLEX.
- **Three-way divergence in TMR:** all lanes pairwise different → FAIL.
- **Clear and reset:** `err_clear_i` asserted together with a mismatch → counter reads 0; `rst` pulsed in FAIL → TMR with every status output 0.

Source files
------------

// File: rtl/cv32e40p_pkg.sv
// Shared types for the IF/ID fault-tolerant voter: lane bundle layout, voter FSM states,
// and the healthy-lane selection helper.
package cv32e40p_pkg;

    localparam int IF_ID_BUNDLE_W = 68;
    // Streak counters only need to reach thresholds of up to 15.
    localparam int STREAK_W = 4;

    typedef struct packed {
        logic        valid;
        logic [31:0] rdata;
        logic        compressed;
        logic        illegal;
        logic [31:0] pc;
        logic        fetch_failed;
    } if_id_bundle_t;

    typedef enum logic [1:0] {
        VOTE_TMR    = 2'd0,
        VOTE_DUPLEX = 2'd1,
        VOTE_FAIL   = 2'd2
    } if_voter_state_e;

    function automatic logic [1:0] lowest_healthy(input logic [2:0] faulty);
        if (!faulty[0]) return 2'd0;
        if (!faulty[1]) return 2'd1;
        if (!faulty[2]) return 2'd2;
        return 2'd0;
    endfunction

endpackage

// File: rtl/cv32e40p_bitwise_voter.sv
// Bitwise 2-of-3 majority voter with per-word disagreement flags.
module cv32e40p_bitwise_voter #(
    parameter int WIDTH = 68
) (
    input  logic [WIDTH-1:0] word0,
    input  logic [WIDTH-1:0] word1,
    input  logic [WIDTH-1:0] word2,
    output logic [WIDTH-1:0] voted,
    output logic [2:0]       mm,
    output logic             no_match
);

    assign voted    = (word0 & word1) | (word0 & word2) | (word1 & word2);
    assign mm       = {word2 != voted, word1 != voted, word0 != voted};
    // Bitwise majority can differ from every input when all three disagree.
    assign no_match = &mm;

endmodule

// File: rtl/cv32e40p_if_id_voter.sv
// Votes the triplicated IF/ID registers into one ID-stage view, retires lanes that keep
// disagreeing, and requests a refetch when the mismatch cannot be masked.
module cv32e40p_if_id_voter
    import cv32e40p_pkg::*;
#(
    parameter bit          FT_ENABLE     = 1'b1,
    parameter int unsigned ERR_THRESHOLD = 4,
    parameter int unsigned CNT_WIDTH     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [2:0]           instr_valid_id_i,
    input  logic [2:0][31:0]     instr_rdata_id_i,
    input  logic [2:0]           is_compressed_id_i,
    input  logic [2:0]           illegal_c_insn_id_i,
    input  logic [2:0][31:0]     pc_id_i,
    input  logic [2:0]           is_fetch_failed_i,
    output logic                 instr_valid_o,
    output logic [31:0]          instr_rdata_o,
    output logic [31:0]          pc_o,
    output logic                 is_compressed_o,
    output logic                 illegal_c_insn_o,
    output logic                 is_fetch_failed_o,
    output logic                 err_corrected_o,
    output logic                 err_uncorrectable_o,
    output logic [2:0]           lane_faulty_o,
    output logic [CNT_WIDTH-1:0] err_count_o,
    input  logic                 err_clear_i,
    output logic                 refetch_req_o,
    input  logic                 refetch_ack_i
);

    localparam logic [STREAK_W-1:0] THR = STREAK_W'(ERR_THRESHOLD);

    if_id_bundle_t                 lane [3];
    if_id_bundle_t                 voted;
    if_id_bundle_t                 healthy_sel;
    if_id_bundle_t                 out_bundle;
    logic [2:0]                    mm;
    logic                          no_match;
    logic                          duplex_diff;
    logic                          uncorrectable;
    logic                          any_err;
    logic [2:0]                    threshold_hit;

    if_voter_state_e               state_q, state_d;
    logic [2:0]                    lane_faulty_q, lane_faulty_d;
    logic [2:0][STREAK_W-1:0]      streak_q, streak_d;
    logic [CNT_WIDTH-1:0]          err_count_q, err_count_d;
    logic                          err_corrected_q, err_corrected_d;
    logic                          err_uncorrectable_q, err_uncorrectable_d;

    for (genvar g = 0; g < 3; g++) begin : g_lane
        assign lane[g] = '{
            valid:        instr_valid_id_i[g],
            rdata:        instr_rdata_id_i[g],
            compressed:   is_compressed_id_i[g],
            illegal:      illegal_c_insn_id_i[g],
            pc:           pc_id_i[g],
            fetch_failed: is_fetch_failed_i[g]
        };
    end

    cv32e40p_bitwise_voter #(
        .WIDTH(IF_ID_BUNDLE_W)
    ) u_voter (
        .word0    (lane[0]),
        .word1    (lane[1]),
        .word2    (lane[2]),
        .voted    (voted),
        .mm       (mm),
        .no_match (no_match)
    );

    // With one lane retired, the two survivors are compared directly.
    always_comb begin : p_duplex
        unique case (lowest_healthy(lane_faulty_q))
            2'd1:    healthy_sel = lane[1];
            2'd2:    healthy_sel = lane[2];
            default: healthy_sel = lane[0];
        endcase
        unique case (lane_faulty_q)
            3'b001:  duplex_diff = (lane[1] != lane[2]);
            3'b010:  duplex_diff = (lane[0] != lane[2]);
            3'b100:  duplex_diff = (lane[0] != lane[1]);
            default: duplex_diff = 1'b0;
        endcase
    end

    always_comb begin : p_next
        // NOTE: every variable driven here gets a default first, so no path can infer a latch.
        state_d             = state_q;
        lane_faulty_d       = lane_faulty_q;
        streak_d            = streak_q;
        err_count_d         = err_count_q;
        err_corrected_d     = 1'b0;
        err_uncorrectable_d = 1'b0;
        threshold_hit       = '0;
        any_err             = 1'b0;
        out_bundle          = voted;
        uncorrectable       = 1'b0;

        unique case (state_q)
            VOTE_TMR: begin
                out_bundle    = voted;
                uncorrectable = no_match;
            end
            VOTE_DUPLEX: begin
                out_bundle    = healthy_sel;
                uncorrectable = duplex_diff;
            end
            default: out_bundle = (|lane_faulty_q) ? healthy_sel : voted;
        endcase

        // Error tracking is frozen while waiting for the refetch handshake.
        if (state_q != VOTE_FAIL) begin
            for (int i = 0; i < 3; i++) begin
                if (!lane_faulty_q[i]) begin
                    if (mm[i]) begin
                        if (streak_q[i] != THR) streak_d[i] = streak_q[i] + 1'b1;
                        if (streak_q[i] == THR - 1'b1) threshold_hit[i] = 1'b1;
                    end else begin
                        streak_d[i] = '0;
                    end
                end
            end
            any_err             = (|(mm & ~lane_faulty_q)) | uncorrectable;
            err_corrected_d     = any_err & ~uncorrectable;
            err_uncorrectable_d = uncorrectable;
            lane_faulty_d       = lane_faulty_q | threshold_hit;
            if (any_err && (err_count_q != '1)) err_count_d = err_count_q + 1'b1;
        end

        if (err_clear_i) begin
            err_count_d   = '0;
            lane_faulty_d = '0;
            streak_d      = '0;
        end

        unique case (state_q)
            VOTE_TMR: begin
                if (uncorrectable || ($countones(threshold_hit) > 1)) state_d = VOTE_FAIL;
                else if (|threshold_hit)                              state_d = VOTE_DUPLEX;
                if (err_clear_i) state_d = VOTE_TMR;
            end
            VOTE_DUPLEX: begin
                if (uncorrectable || (|threshold_hit)) state_d = VOTE_FAIL;
                if (err_clear_i) state_d = VOTE_TMR;
            end
            default: begin
                if (refetch_ack_i) state_d = (|lane_faulty_d) ? VOTE_DUPLEX : VOTE_TMR;
            end
        endcase

        if (!FT_ENABLE) begin
            out_bundle          = lane[0];
            uncorrectable       = 1'b0;
            state_d             = VOTE_TMR;
            lane_faulty_d       = '0;
            streak_d            = '0;
            err_count_d         = '0;
            err_corrected_d     = 1'b0;
            err_uncorrectable_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin : p_regs
        if (rst) begin
            state_q             <= VOTE_TMR;
            lane_faulty_q       <= '0;
            streak_q            <= '0;
            err_count_q         <= '0;
            err_corrected_q     <= 1'b0;
            err_uncorrectable_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q             <= state_d;
            lane_faulty_q       <= lane_faulty_d;
            streak_q            <= streak_d;
            err_count_q         <= err_count_d;
            err_corrected_q     <= err_corrected_d;
            err_uncorrectable_q <= err_uncorrectable_d;
        end
    end

    // A corrupted instruction is suppressed in the same cycle it is seen.
    assign instr_valid_o       = out_bundle.valid & ~uncorrectable & (state_q != VOTE_FAIL);
    assign instr_rdata_o       = out_bundle.rdata;
    assign pc_o                = out_bundle.pc;
    assign is_compressed_o     = out_bundle.compressed;
    assign illegal_c_insn_o    = out_bundle.illegal;
    assign is_fetch_failed_o   = out_bundle.fetch_failed;
    assign err_corrected_o     = err_corrected_q;
    assign err_uncorrectable_o = err_uncorrectable_q;
    assign lane_faulty_o       = lane_faulty_q;
    assign err_count_o         = err_count_q;
    assign refetch_req_o       = (state_q == VOTE_FAIL);

endmodule

// File: tb/tb_cv32e40p_if_id_voter.sv
// Scoreboard bench for cv32e40p_if_id_voter: directed scenarios followed by random traffic,
// checked against a lane-level reference model.
module tb_cv32e40p_if_id_voter;

    localparam int THR    = 4;
    localparam int M_TMR  = 0;
    localparam int M_DUP  = 1;
    localparam int M_FAIL = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [2:0]       instr_valid_id_i = '0;
    logic [2:0][31:0] instr_rdata_id_i = '0;
    logic [2:0]       is_compressed_id_i = '0;
    logic [2:0]       illegal_c_insn_id_i = '0;
    logic [2:0][31:0] pc_id_i = '0;
    logic [2:0]       is_fetch_failed_i = '0;
    logic             err_clear_i = 1'b0;
    logic             refetch_ack_i = 1'b0;
    logic             instr_valid_o;
    logic [31:0]      instr_rdata_o;
    logic [31:0]      pc_o;
    logic             is_compressed_o;
    logic             illegal_c_insn_o;
    logic             is_fetch_failed_o;
    logic             err_corrected_o;
    logic             err_uncorrectable_o;
    logic [2:0]       lane_faulty_o;
    logic [15:0]      err_count_o;
    logic             refetch_req_o;

    cv32e40p_if_id_voter dut (
        .clk                 (clk),
        .rst                 (rst),
        .instr_valid_id_i    (instr_valid_id_i),
        .instr_rdata_id_i    (instr_rdata_id_i),
        .is_compressed_id_i  (is_compressed_id_i),
        .illegal_c_insn_id_i (illegal_c_insn_id_i),
        .pc_id_i             (pc_id_i),
        .is_fetch_failed_i   (is_fetch_failed_i),
        .instr_valid_o       (instr_valid_o),
        .instr_rdata_o       (instr_rdata_o),
        .pc_o                (pc_o),
        .is_compressed_o     (is_compressed_o),
        .illegal_c_insn_o    (illegal_c_insn_o),
        .is_fetch_failed_o   (is_fetch_failed_o),
        .err_corrected_o     (err_corrected_o),
        .err_uncorrectable_o (err_uncorrectable_o),
        .lane_faulty_o       (lane_faulty_o),
        .err_count_o         (err_count_o),
        .err_clear_i         (err_clear_i),
        .refetch_req_o       (refetch_req_o),
        .refetch_ack_i       (refetch_ack_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          step;
        bit          check_data;
        logic        valid;
        logic [31:0] rdata;
        logic [31:0] pc;
        logic        comp;
        logic        ill;
        logic        ff;
        logic        corr;
        logic        unc;
        logic [2:0]  faulty;
        logic [15:0] cnt;
        logic        req;
    } exp_t;

    exp_t        sb [$];
    int          checks   = 0;
    int          failures = 0;
    int          step_no  = 0;

    // Reference model state: what the DUT registers hold during the current cycle.
    int          m_mode;
    int          m_streak [3];
    logic [2:0]  m_faulty;
    int          m_cnt;
    bit          m_corr;
    bit          m_unc;
    logic [67:0] lanes_v [3];

    // Lane vector layout: {valid, rdata[31:0], compressed, illegal, pc[31:0], fetch_failed}.
    function automatic logic [67:0] mk(input logic v, input logic [31:0] rd, input logic [31:0] pc);
        return {v, rd, 1'b0, 1'b0, pc, 1'b0};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp, input int step);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step=%0d got=0x%0h expected=0x%0h", name, step, act, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = M_TMR;
        for (int i = 0; i < 3; i++) m_streak[i] = 0;
        m_faulty = '0;
        m_cnt    = 0;
        m_corr   = 1'b0;
        m_unc    = 1'b0;
    endtask

    task automatic model_step(input bit clr, input bit ack, input bit rst_v);
        logic [67:0] maj;
        logic [67:0] sel;
        bit          mmv [3];
        int          h [$];
        int          sel_idx;
        int          old_mode;
        int          hits;
        bit          unc;
        bit          anyerr;
        exp_t        e;

        if (rst_v) model_reset();
        for (int b = 0; b < 68; b++) begin
            int ones;
            ones = int'(lanes_v[0][b]) + int'(lanes_v[1][b]) + int'(lanes_v[2][b]);
            maj[b] = (ones >= 2);
        end
        for (int i = 0; i < 3; i++) mmv[i] = (lanes_v[i] != maj);
        for (int i = 0; i < 3; i++) if (!m_faulty[i]) h.push_back(i);
        sel_idx = (h.size() > 0) ? h[0] : 0;

        unc = 1'b0;
        if (m_mode == M_TMR) begin
            sel = maj;
            unc = mmv[0] && mmv[1] && mmv[2];
        end else if (m_mode == M_DUP) begin
            sel = lanes_v[sel_idx];
            unc = (h.size() == 2) && (lanes_v[h[0]] != lanes_v[h[1]]);
        end else begin
            sel = (m_faulty != 0) ? lanes_v[sel_idx] : maj;
        end

        e.step       = step_no;
        e.check_data = (m_mode != M_FAIL);
        e.valid      = sel[67] && !unc && (m_mode != M_FAIL);
        e.rdata      = sel[66:35];
        e.comp       = sel[34];
        e.ill        = sel[33];
        e.pc         = sel[32:1];
        e.ff         = sel[0];
        e.corr       = m_corr;
        e.unc        = m_unc;
        e.faulty     = m_faulty;
        e.cnt        = 16'(m_cnt);
        e.req        = (m_mode == M_FAIL);
        sb.push_back(e);
        step_no++;

        if (rst_v) return;

        old_mode = m_mode;
        if (old_mode != M_FAIL) begin
            anyerr = unc;
            hits   = 0;
            for (int i = 0; i < 3; i++) begin
                if (!m_faulty[i]) begin
                    if (mmv[i]) begin
                        anyerr = 1'b1;
                        if (m_streak[i] < THR) begin
                            m_streak[i]++;
                            if (m_streak[i] == THR) begin
                                m_faulty[i] = 1'b1;
                                hits++;
                            end
                        end
                    end else begin
                        m_streak[i] = 0;
                    end
                end
            end
            m_corr = anyerr && !unc;
            m_unc  = unc;
            if (anyerr && m_cnt < 65535) m_cnt++;
            if (old_mode == M_TMR) begin
                if (unc || hits >= 2) m_mode = M_FAIL;
                else if (hits == 1)   m_mode = M_DUP;
            end else if (unc || hits > 0) begin
                m_mode = M_FAIL;
            end
        end else begin
            m_corr = 1'b0;
            m_unc  = 1'b0;
        end

        if (clr) begin
            m_cnt    = 0;
            m_faulty = '0;
            for (int i = 0; i < 3; i++) m_streak[i] = 0;
            if (old_mode != M_FAIL) m_mode = M_TMR;
        end
        if (old_mode == M_FAIL && ack) m_mode = (m_faulty != 0) ? M_DUP : M_TMR;
    endtask

    task automatic drive(input logic [67:0] a, input logic [67:0] b, input logic [67:0] c,
                         input bit clr, input bit ack, input bit rst_v);
        @(posedge clk);
        #1;
        lanes_v[0] = a;
        lanes_v[1] = b;
        lanes_v[2] = c;
        for (int i = 0; i < 3; i++) begin
            instr_valid_id_i[i]    = lanes_v[i][67];
            instr_rdata_id_i[i]    = lanes_v[i][66:35];
            is_compressed_id_i[i]  = lanes_v[i][34];
            illegal_c_insn_id_i[i] = lanes_v[i][33];
            pc_id_i[i]             = lanes_v[i][32:1];
            is_fetch_failed_i[i]   = lanes_v[i][0];
        end
        rst           = rst_v;
        err_clear_i   = clr;
        refetch_ack_i = ack;
        model_step(clr, ack, rst_v);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("instr_valid", 32'(instr_valid_o), 32'(e.valid), e.step);
                if (e.check_data) begin
                    check("instr_rdata", instr_rdata_o, e.rdata, e.step);
                    check("pc", pc_o, e.pc, e.step);
                    check("is_compressed", 32'(is_compressed_o), 32'(e.comp), e.step);
                    check("illegal_c_insn", 32'(illegal_c_insn_o), 32'(e.ill), e.step);
                    check("is_fetch_failed", 32'(is_fetch_failed_o), 32'(e.ff), e.step);
                end
                check("err_corrected", 32'(err_corrected_o), 32'(e.corr), e.step);
                check("err_uncorrectable", 32'(err_uncorrectable_o), 32'(e.unc), e.step);
                check("lane_faulty", 32'(lane_faulty_o), 32'(e.faulty), e.step);
                check("err_count", 32'(err_count_o), 32'(e.cnt), e.step);
                check("refetch_req", 32'(refetch_req_o), 32'(e.req), e.step);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog simulation did not finish in time checks=%0d", checks);
        $fatal(1);
    end

    initial begin : stimulus
        logic [67:0] clean;
        logic [67:0] flip5;
        logic [67:0] pc_bad;
        logic [67:0] l [3];
        int          sticky      = 0;
        int          sticky_left = 0;

        model_reset();
        clean  = mk(1'b1, 32'h00A0_0093, 32'h0000_0080);
        flip5  = mk(1'b1, 32'h00A0_0093 ^ 32'h20, 32'h0000_0080);
        pc_bad = mk(1'b1, 32'h00A0_0093, 32'h0000_0084);

        // Reset with IF registers cleared.
        drive('0, '0, '0, 1'b0, 1'b0, 1'b1);
        drive('0, '0, '0, 1'b0, 1'b0, 1'b1);
        // Clean traffic.
        repeat (3) drive(clean, clean, clean, 1'b0, 1'b0, 1'b0);
        // Single-cycle flip on lane 1.
        drive(clean, flip5, clean, 1'b0, 1'b0, 1'b0);
        repeat (2) drive(clean, clean, clean, 1'b0, 1'b0, 1'b0);
        // Persistent pc fault on lane 2 retires it; stays masked in duplex.
        repeat (6) drive(clean, clean, pc_bad, 1'b0, 1'b0, 1'b0);
        // Healthy lanes disagree in duplex: refetch held until ack on the third cycle.
        drive(clean, flip5, clean, 1'b0, 1'b0, 1'b0);
        repeat (2) drive(clean, clean, clean, 1'b0, 1'b0, 1'b0);
        drive(clean, clean, clean, 1'b0, 1'b1, 1'b0);
        repeat (2) drive(clean, clean, pc_bad, 1'b0, 1'b0, 1'b0);
        // Clear back to TMR, then clear coinciding with a mismatch.
        drive(clean, clean, clean, 1'b1, 1'b0, 1'b0);
        drive(flip5, clean, clean, 1'b0, 1'b0, 1'b0);
        drive(clean, clean, flip5, 1'b1, 1'b0, 1'b0);
        drive(clean, clean, clean, 1'b0, 1'b0, 1'b0);
        // Three-way divergence in TMR.
        drive(mk(1'b1, 32'h00A0_0092, 32'h80), mk(1'b1, 32'h00A0_0091, 32'h80),
              mk(1'b1, 32'h00A0_0097, 32'h80), 1'b0, 1'b0, 1'b0);
        repeat (2) drive(clean, clean, clean, 1'b0, 1'b0, 1'b0);
        // Reset pulse while in FAIL.
        drive(clean, clean, clean, 1'b0, 1'b0, 1'b1);
        repeat (2) drive(clean, clean, clean, 1'b0, 1'b0, 1'b0);

        // Random traffic with sticky lane faults, occasional multi-lane faults, acks and clears.
        for (int n = 0; n < 3000; n++) begin
            logic [67:0] base;
            int          r;
            base = {$urandom(), $urandom(), 4'($urandom())};
            for (int k = 0; k < 3; k++) l[k] = base;
            if (sticky_left == 0 && ($urandom() % 16) == 0) begin
                sticky      = int'($urandom() % 3);
                sticky_left = 1 + int'($urandom() % 6);
            end
            if (sticky_left > 0) begin
                int idx;
                idx = int'($urandom() % 68);
                l[sticky][idx] = ~l[sticky][idx];
                sticky_left--;
            end
            r = int'($urandom() % 32);
            if (r <= 4) begin
                int k;
                int idx;
                k   = int'($urandom() % 3);
                idx = int'($urandom() % 68);
                l[k][idx] = ~l[k][idx];
            end else if (r == 5) begin
                for (int k = 0; k < 3; k++) l[k][k * 20 + int'($urandom() % 8)] ^= 1'b1;
            end
            drive(l[0], l[1], l[2], ($urandom() % 48) == 0, ($urandom() % 4) == 0,
                  ($urandom() % 600) == 0);
        end

        drive(clean, clean, clean, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("scoreboard_drained", 32'(sb.size()), 32'd0, step_no);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
